// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 mouse interface: canned host command frames,
// the host transmitter state encoding and frame/parity helpers.
// -----------------------------------------------------------------------------
package ps2_pkg;

   // 11-bit frames: bit0 start (0), bits 8:1 data LSB first, bit9 odd parity,
   // bit10 stop (1).
   localparam logic [10:0] EN_REPORTING = 11'h5E8;  // data 8'hF4
   localparam logic [10:0] RESET_CMD    = 11'h7FE;  // data 8'hFF
   localparam logic [10:0] ACK          = 11'h7F4;  // data 8'hFA

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SEND,
      WAIT_ACK,
      WAIT_IDLE
   } tx_state_e;

   // Parity bit that makes the total count of ones in {parity, data} odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

   // A frame is well formed when start is 0, stop is 1 and parity is odd.
   function automatic logic frame_ok(input logic [10:0] frame);
      return (frame[0] == 1'b0) && (frame[10] == 1'b1) &&
             (frame[9] == odd_parity(frame[8:1]));
   endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// -----------------------------------------------------------------------------
// ps2_sync_edge
// Two-flop synchroniser for one raw PS/2 pad level plus a falling-edge detector
// on the synchronised value.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   din    : raw asynchronous pad level
//   dout   : synchronised level
//   fall   : high for one cycle when dout goes 1 -> 0
// -----------------------------------------------------------------------------
module ps2_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic fall
);

   logic meta_q, sync_q, prev_q;
   logic meta_d, sync_d, prev_d;

   always_comb begin
      meta_d = din;
      sync_d = meta_q;
      prev_d = sync_q;
   end

   // NOTE: the chain resets to 1, the idle level of an open-drain PS/2 line,
   // so leaving reset never fabricates a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments keep this a true shift chain;
         // blocking ones would collapse it to a single flop.
         meta_q <= meta_d;
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign dout = sync_q;
   assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Runs the request-to-send sequence, shifts an
// 11-bit frame out on device clock falling edges and checks the line ack.
//   clk_25MHz, reset_n      : clock, asynchronous active-low reset
//   tx_data[10:0], write    : frame and transmit request from the control FSM
//   ps2_clk_in, ps2_data_in : raw pad levels
//   ps2_clk_oe, ps2_data_oe : 1 pulls the corresponding pad low
//   busy, done, err         : status; done/err are one-cycle pulses
// -----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned INHIBIT_CYCLES = 2500,
   parameter int unsigned TIMEOUT_CYCLES = 375000
) (
   input  logic        clk_25MHz,
   input  logic        reset_n,
   input  logic [10:0] tx_data,
   input  logic        write,
   input  logic        ps2_clk_in,
   input  logic        ps2_data_in,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] INHIBIT_LOAD = CW'(INHIBIT_CYCLES);
   localparam logic [CW-1:0] TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] CNT_ONE      = CW'(1);

   logic clk_sync, clk_fall, data_sync, data_fall;

   ps2_sync_edge u_clk_sync (
      .clk  (clk_25MHz),
      .rst_n(reset_n),
      .din  (ps2_clk_in),
      .dout (clk_sync),
      .fall (clk_fall)
   );

   ps2_sync_edge u_data_sync (
      .clk  (clk_25MHz),
      .rst_n(reset_n),
      .din  (ps2_data_in),
      .dout (data_sync),
      .fall (data_fall)
   );

   tx_state_e     state_q, state_d;
   logic [10:0]   shreg_q, shreg_d;
   logic [3:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          clk_oe_q, clk_oe_d;
   logic          data_oe_q, data_oe_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          expired;

   // The counter is "reaching 0" on the cycle it would decrement from 1, so a
   // state loaded with N lasts exactly N cycles.
   assign expired = (cnt_q <= CNT_ONE);

   // NOTE: every signal gets a default first so no path through the case
   // leaves it unassigned, which would infer a latch.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      clk_oe_d  = clk_oe_q;
      data_oe_d = data_oe_q;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            if (write) begin
               shreg_d = tx_data;
               if (!frame_ok(tx_data)) begin
                  err_d = 1'b1;
               end else begin
                  state_d  = INHIBIT;
                  cnt_d    = INHIBIT_LOAD;
                  clk_oe_d = 1'b1;
               end
            end
         end

         INHIBIT: begin
            clk_oe_d = 1'b1;
            if (expired) begin
               state_d   = RTS;
               cnt_d     = '0;
               data_oe_d = 1'b1;  // start bit goes out while clock still held
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         RTS: begin
            state_d  = SEND;
            idx_d    = 4'd1;
            clk_oe_d = 1'b0;
            cnt_d    = TIMEOUT_LOAD;
         end

         SEND: begin
            // A device edge wins over a simultaneous timeout.
            if (clk_fall) begin
               data_oe_d = ~shreg_q[idx_q];
               idx_d     = idx_q + 4'd1;
               cnt_d     = TIMEOUT_LOAD;
               if (idx_q == 4'd10) state_d = WAIT_ACK;
            end else if (expired) begin
               state_d   = IDLE;
               cnt_d     = '0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         WAIT_ACK: begin
            if (clk_fall) begin
               if (!data_sync) begin
                  state_d = WAIT_IDLE;
                  cnt_d   = TIMEOUT_LOAD;
               end else begin
                  state_d = IDLE;
                  err_d   = 1'b1;
               end
            end else if (expired) begin
               state_d   = IDLE;
               cnt_d     = '0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end else if (expired) begin
               state_d   = IDLE;
               cnt_d     = '0;
               clk_oe_d  = 1'b0;
               data_oe_d = 1'b0;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         default: begin
            state_d   = IDLE;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk_25MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         clk_oe_q  <= clk_oe_d;
         data_oe_q <= data_oe_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

   // Data-line falling edges are not needed by the transmitter.
   logic unused_data_fall;
   assign unused_data_fall = data_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Frames expected at the device are queued when sent and compared when the
// device model has clocked a full frame in.
// -----------------------------------------------------------------------------
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH = 2500;
   localparam int TO  = 4000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [10:0] tx_data = '0;
   logic        write = 1'b0;
   logic        ps2_clk_in, ps2_data_in;
   logic        ps2_clk_oe, ps2_data_oe, busy, done, err;
   logic        dev_clk_low = 1'b0;
   logic        dev_data_low = 1'b0;

   // Open-drain wired-AND of host and device pull-downs.
   assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk_25MHz  (clk),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .write      (write),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #20 clk = ~clk;

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Scoreboard of frames the device should receive.
   logic [10:0] sb[$];

   // Monitor, sampled on the inactive edge.
   int cyc = 0, run = 0, last_run = 0, rts_cyc = 0, err_cyc = 0;
   int done_cnt = 0, err_cnt = 0, dev_edges = 0;
   always @(negedge clk) begin
      cyc++;
      if (ps2_clk_oe) run++;
      else if (run != 0) begin
         last_run = run;
         run = 0;
      end
      if (ps2_clk_oe && ps2_data_oe) rts_cyc = cyc;
      if (err) begin
         err_cyc = cyc;
         err_cnt++;
      end
      if (done) done_cnt++;
   end

   task automatic send(input logic [10:0] f);
      @(negedge clk);
      tx_data = f;
      write   = 1'b1;
      @(negedge clk);
      write   = 1'b0;
   endtask

   // Device: waits for request-to-send, clocks in up to 11 bits sampling on
   // the rising clock, then drives (or withholds) the ack on the 11th clock.
   task automatic device(input int h, input bit ack, input int n_edges);
      logic [10:0] rx;
      int w;
      rx = '0;
      w  = 0;
      while (!(ps2_data_in == 1'b0 && ps2_clk_in == 1'b1) && w < INH + 200) begin
         @(negedge clk);
         w++;
      end
      check("rts_seen", {ps2_clk_in, ps2_data_in}, 2'b10);
      if (!(ps2_data_in == 1'b0 && ps2_clk_in == 1'b1)) return;
      repeat (h) @(negedge clk);
      rx[0] = ps2_data_in;
      for (int k = 1; k <= 10; k++) begin
         if (k > n_edges) return;
         dev_clk_low = 1'b1;
         dev_edges++;
         repeat (h) @(negedge clk);
         dev_clk_low = 1'b0;
         rx[k] = ps2_data_in;
         repeat (h) @(negedge clk);
      end
      if (n_edges < 11) return;
      dev_data_low = ack;
      repeat (h / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      dev_edges++;
      repeat (h) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (h / 4) @(negedge clk);
      dev_data_low = 1'b0;
      if (sb.size() == 0) check("sb_empty", 32'(sb.size()), 1);
      else check("frame", rx, sb.pop_front());
   endtask

   // Waits for the done/err pulse and checks the cycle it appears in.
   task automatic wait_result(input string tag, input bit exp_done, input int budget);
      int w;
      w = 0;
      while (!(done || err) && w < budget) begin
         @(negedge clk);
         w++;
      end
      check({tag, "_result"}, {done, err}, exp_done ? 2'b10 : 2'b01);
      check({tag, "_idle"}, {busy, ps2_clk_oe, ps2_data_oe}, 3'b000);
      @(negedge clk);
      check({tag, "_pulse"}, {done, err}, 2'b00);
   endtask

   initial begin
      #(200000 * 40);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, e0, w;
      logic seen;

      // Reset state.
      #5;
      check("reset_outs", {ps2_clk_oe, ps2_data_oe, busy, done, err}, 5'b0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);

      // Valid enable-reporting frame, device at 12.5 kHz.
      d0 = done_cnt;
      sb.push_back(EN_REPORTING);
      send(EN_REPORTING);
      check("accept_busy", {busy, ps2_clk_oe}, 2'b11);
      fork
         device(1000, 1'b1, 11);
         wait_result("en_rep", 1'b1, 40000);
      join
      check("inhibit_len", 32'(last_run), 32'(INH + 1));
      repeat (5) @(negedge clk);
      check("en_rep_done_once", 32'(done_cnt - d0), 1);

      // Bad parity: error next cycle, no pad activity.
      e0 = err_cnt;
      send(11'h7E8);
      check("badpar_err", {err, busy}, 2'b10);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         seen |= ps2_clk_oe | ps2_data_oe | busy;
      end
      check("badpar_pads", seen, 1'b0);
      check("badpar_err_once", 32'(err_cnt - e0), 1);

      // Device never clocks: timeout after the RTS cycle.
      send(EN_REPORTING);
      wait_result("timeout", 1'b0, INH + TO + 100);
      // SEND waits TO cycles after RTS; err shows on the first IDLE cycle.
      check("timeout_latency", 32'(err_cyc - rts_cyc), 32'(TO + 1));

      // Missing acknowledge.
      d0 = done_cnt;
      sb.push_back(EN_REPORTING);
      send(EN_REPORTING);
      fork
         device(100, 1'b0, 11);
         wait_result("nack", 1'b0, 20000);
      join
      repeat (100) @(negedge clk);
      check("nack_no_done", 32'(done_cnt - d0), 0);

      // Write while busy is ignored.
      sb.push_back(EN_REPORTING);
      send(EN_REPORTING);
      d0 = dev_edges;
      fork
         device(100, 1'b1, 11);
         wait_result("busy_wr", 1'b1, 20000);
         begin
            w = 0;
            while (dev_edges < d0 + 3 && w < 20000) begin
               @(negedge clk);
               w++;
            end
            @(negedge clk);
            tx_data = RESET_CMD;
            write   = 1'b1;
            @(negedge clk);
            write   = 1'b0;
         end
      join
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         seen |= busy;
      end
      check("busy_wr_no_queue", seen, 1'b0);

      // Reset mid-frame releases the pads at once.
      send(RESET_CMD);
      device(100, 1'b1, 4);
      check("pre_rst_busy", busy, 1'b1);
      #7 reset_n = 1'b0;
      #1 check("rst_pads", {ps2_clk_oe, ps2_data_oe, busy}, 3'b000);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      sb.push_back(RESET_CMD);
      send(RESET_CMD);
      fork
         device(100, 1'b1, 11);
         wait_result("post_rst", 1'b1, 20000);
      join
      check("sb_drained", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
